// File: rtl/prim_event_sync_rx_if.sv
// Bundle of per-channel event, handshake and status signals for
// prim_event_sync_rx. The receiver takes the slave modport; the
// producer of toggles and consumer of events takes the master modport.
interface prim_event_sync_rx_if #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned CntW  = 4
);

  logic [NumCh-1:0]      toggle_i;   // asynchronous toggle levels
  logic [NumCh-1:0]      pulse_o;    // one-cycle event pulse per toggle
  logic [NumCh-1:0]      valid_o;    // channel has pending events
  logic [NumCh-1:0]      ready_i;    // consumer pops one pending event
  logic [NumCh*CntW-1:0] count_o;    // pending count, channel c at [c*CntW +: CntW]
  logic [NumCh-1:0]      ovf_o;      // sticky event-lost flag
  logic [NumCh-1:0]      ovf_clr_i;  // clears ovf_o per channel

  // Receiver side.
  modport slave (
    input  toggle_i,
    input  ready_i,
    input  ovf_clr_i,
    output pulse_o,
    output valid_o,
    output count_o,
    output ovf_o
  );

  // Toggle source / event consumer side.
  modport master (
    output toggle_i,
    output ready_i,
    output ovf_clr_i,
    input  pulse_o,
    input  valid_o,
    input  count_o,
    input  ovf_o
  );

endinterface

// File: rtl/prim_event_sync_rx.sv
// Multi-channel receiver for toggle-encoded events entering the clk_i
// domain. Each channel synchronises its toggle level, turns every level
// change into a one-cycle pulse and, in counted mode, buffers events in a
// saturating pending counter drained by a valid/ready handshake with a
// sticky overflow flag. A shared init window masks the events that a
// toggle level already high at reset release would otherwise create.
module prim_event_sync_rx #(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned CntW       = 4,
  parameter bit          Counted    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  prim_event_sync_rx_if.slave bus
);

  // Init window length: SyncStages+1 cycles after reset release, long
  // enough for a pre-existing high level to reach both sync and prev.
  localparam int unsigned      InitW   = $clog2(SyncStages + 2);
  localparam logic [InitW-1:0] InitLen = InitW'(SyncStages + 1);

  // Synchroniser chain, stage 0 samples the asynchronous toggle level.
  logic [SyncStages-1:0][NumCh-1:0] sync_q, sync_d;
  logic [NumCh-1:0]                 sync;
  logic [NumCh-1:0]                 prev_q, prev_d;
  logic [InitW-1:0]                 init_cnt_q, init_cnt_d;
  logic                             init;
  logic [NumCh-1:0]                 event_raw;
  logic [NumCh-1:0]                 event_vld;

  assign sync = sync_q[SyncStages-1];
  assign init = |init_cnt_q;

  // Next state of the synchroniser, edge detector and init window.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    sync_d     = {sync_q[SyncStages-2:0], bus.toggle_i};
    prev_d     = sync;
    init_cnt_d = init_cnt_q;
    if (init) begin
      init_cnt_d = init_cnt_q - InitW'(1);
    end
  end

  // Synchroniser, prev and init-window registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      prev_q     <= '0;
      // NOTE: the init counter resets to its armed value, not zero, so the window restarts on every release.
      init_cnt_q <= InitLen;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Raw level change, masked while the init window is open. Both terms
  // come straight from flops, so the pulse has no input-driven glitches.
  assign event_raw   = sync ^ prev_q;
  assign event_vld   = event_raw & {NumCh{~init}};
  assign bus.pulse_o = event_vld;

  if (Counted) begin : g_counted

    localparam logic [CntW-1:0] CntMax = '1;

    logic [NumCh-1:0][CntW-1:0] count_q, count_d;
    logic [NumCh-1:0]           ovf_q, ovf_d;
    logic [NumCh-1:0]           valid;
    logic [NumCh-1:0]           push;
    logic [NumCh-1:0]           pop;
    logic [NumCh-1:0]           lost;

    // Pending-counter and overflow next state, one independent lane per channel.
    always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      valid   = '0;
      push    = '0;
      pop     = '0;
      lost    = '0;
      for (int c = 0; c < int'(NumCh); c++) begin
        valid[c] = |count_q[c];
        push[c]  = event_vld[c];
        pop[c]   = valid[c] & bus.ready_i[c];
        if (push[c] && !pop[c]) begin
          if (count_q[c] != CntMax) begin
            count_d[c] = count_q[c] + CntW'(1);
          end else begin
            lost[c] = 1'b1;
          end
        end else if (!push[c] && pop[c]) begin
          count_d[c] = count_q[c] - CntW'(1);
        end
        // A lost event wins over a coincident clear.
        if (lost[c]) begin
          ovf_d[c] = 1'b1;
        end else if (bus.ovf_clr_i[c]) begin
          ovf_d[c] = 1'b0;
        end
      end
    end

    // Pending-counter and overflow registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_q <= '0;
        ovf_q   <= '0;
      end else begin
        count_q <= count_d;
        ovf_q   <= ovf_d;
      end
    end

    // valid depends only on the count flops, never on ready_i.
    assign bus.valid_o = valid;
    assign bus.count_o = count_q;
    assign bus.ovf_o   = ovf_q;

  end else begin : g_pulse_only

    // No buffering: the handshake and status outputs are constant and the
    // consumer-side inputs are deliberately left unused.
    logic unused_inputs;
    assign unused_inputs = ^{bus.ready_i, bus.ovf_clr_i};

    assign bus.valid_o = '0;
    assign bus.count_o = '0;
    assign bus.ovf_o   = '0;

  end

endmodule

// File: tb/tb_prim_event_sync_rx.sv
// Directed bench for prim_event_sync_rx. dut_a is a counted receiver
// (SyncStages=2, CntW=2); dut_b is pulse-only (SyncStages=3). Inputs are
// driven and outputs sampled 1 time unit after each rising clk edge.
module tb_prim_event_sync_rx;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prim_event_sync_rx_if #(.NumCh(4), .CntW(2)) ifa ();
  prim_event_sync_rx_if #(.NumCh(4), .CntW(4)) ifb ();

  prim_event_sync_rx #(
    .NumCh(4), .SyncStages(2), .CntW(2), .Counted(1'b1)
  ) dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifa)
  );

  prim_event_sync_rx #(
    .NumCh(4), .SyncStages(3), .CntW(4), .Counted(1'b0)
  ) dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.toggle_i = '0; ifa.ready_i = '0; ifa.ovf_clr_i = '0;
    ifb.toggle_i = '0; ifb.ready_i = '0; ifb.ovf_clr_i = '0;
    step_n(2);
    n_checks++; if (ifa.pulse_o !== 4'b0) begin n_fail++; $display("FAIL rst_pulse_a: got %b exp 0000", ifa.pulse_o); end
    n_checks++; if (ifa.valid_o !== 4'b0) begin n_fail++; $display("FAIL rst_valid_a: got %b exp 0000", ifa.valid_o); end
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL rst_count_a: got %h exp 00", ifa.count_o); end
    n_checks++; if (ifa.ovf_o !== 4'b0) begin n_fail++; $display("FAIL rst_ovf_a: got %b exp 0000", ifa.ovf_o); end
    n_checks++; if (ifb.pulse_o !== 4'b0) begin n_fail++; $display("FAIL rst_pulse_b: got %b exp 0000", ifb.pulse_o); end
    rst = 1'b0;
    step_n(6);
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL post_rst_count_a: got %h exp 00", ifa.count_o); end
  endtask

  task automatic test_basic_latency();
    ifa.toggle_i[0] = ~ifa.toggle_i[0];
    step();  // E0: first stage captures
    n_checks++; if (ifa.pulse_o !== 4'b0000) begin n_fail++; $display("FAIL lat_pulse_e0: got %b exp 0000", ifa.pulse_o); end
    step();  // E1: sync changes
    n_checks++; if (ifa.pulse_o !== 4'b0001) begin n_fail++; $display("FAIL lat_pulse_e1: got %b exp 0001", ifa.pulse_o); end
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL lat_count_e1: got %h exp 00", ifa.count_o); end
    step();  // E2: counter updated
    n_checks++; if (ifa.pulse_o !== 4'b0000) begin n_fail++; $display("FAIL lat_pulse_e2: got %b exp 0000", ifa.pulse_o); end
    n_checks++; if (ifa.count_o !== 8'h01) begin n_fail++; $display("FAIL lat_count_e2: got %h exp 01", ifa.count_o); end
    n_checks++; if (ifa.valid_o !== 4'b0001) begin n_fail++; $display("FAIL lat_valid_e2: got %b exp 0001", ifa.valid_o); end
    ifa.ready_i[0] = 1'b1;
    step();
    ifa.ready_i = '0;
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL lat_pop: got %h exp 00", ifa.count_o); end
    n_checks++; if (ifa.valid_o !== 4'b0000) begin n_fail++; $display("FAIL lat_pop_valid: got %b exp 0000", ifa.valid_o); end
  endtask

  task automatic test_init_suppression();
    logic [3:0] seen;
    int         n_pulse;
    rst = 1'b1;
    ifa.toggle_i = 4'b1010;
    step_n(2);
    rst = 1'b0;
    seen = '0;
    repeat (6) begin step(); seen |= ifa.pulse_o; end
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL init_no_pulse: got %b exp 0000", seen); end
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL init_count: got %h exp 00", ifa.count_o); end
    n_checks++; if (ifa.valid_o !== 4'b0000) begin n_fail++; $display("FAIL init_valid: got %b exp 0000", ifa.valid_o); end
    ifa.toggle_i[1] = 1'b0;
    seen = '0;
    n_pulse = 0;
    repeat (4) begin
      step();
      seen |= ifa.pulse_o;
      if (ifa.pulse_o[1]) n_pulse++;
    end
    n_checks++; if (n_pulse != 1) begin n_fail++; $display("FAIL init_ch1_pulses: got %0d exp 1", n_pulse); end
    n_checks++; if (seen !== 4'b0010) begin n_fail++; $display("FAIL init_ch1_only: got %b exp 0010", seen); end
    n_checks++; if (ifa.count_o !== 8'h04) begin n_fail++; $display("FAIL init_ch1_count: got %h exp 04", ifa.count_o); end
    ifa.ready_i[1] = 1'b1;
    step();
    ifa.ready_i = '0;
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL init_drain: got %h exp 00", ifa.count_o); end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 3; k++) begin
      ifa.toggle_i[2] = ~ifa.toggle_i[2];
      step_n(4);
      n_checks++; if (ifa.count_o[5:4] !== 2'(k)) begin n_fail++; $display("FAIL sat_count_%0d: got %0d exp %0d", k, ifa.count_o[5:4], k); end
      n_checks++; if (ifa.ovf_o !== 4'b0000) begin n_fail++; $display("FAIL sat_ovf_%0d: got %b exp 0000", k, ifa.ovf_o); end
    end
    ifa.toggle_i[2] = ~ifa.toggle_i[2];
    step_n(3);
    n_checks++; if (ifa.ovf_o !== 4'b0100) begin n_fail++; $display("FAIL sat_ovf_set: got %b exp 0100", ifa.ovf_o); end
    n_checks++; if (ifa.count_o !== 8'h30) begin n_fail++; $display("FAIL sat_hold: got %h exp 30", ifa.count_o); end
    step();
    ifa.ovf_clr_i[2] = 1'b1;
    step();
    ifa.ovf_clr_i = '0;
    n_checks++; if (ifa.ovf_o !== 4'b0000) begin n_fail++; $display("FAIL sat_ovf_clr: got %b exp 0000", ifa.ovf_o); end
    ifa.ready_i[2] = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      step();
      n_checks++; if (ifa.count_o[5:4] !== 2'(k)) begin n_fail++; $display("FAIL sat_drain_%0d: got %0d exp %0d", k, ifa.count_o[5:4], k); end
    end
    n_checks++; if (ifa.valid_o[2] !== 1'b0) begin n_fail++; $display("FAIL sat_drain_valid: got %b exp 0", ifa.valid_o[2]); end
    step();  // ready held while empty must not underflow
    ifa.ready_i = '0;
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL sat_no_underflow: got %h exp 00", ifa.count_o); end
  endtask

  task automatic test_simul_push_pop();
    for (int k = 0; k < 3; k++) begin
      ifa.toggle_i[2] = ~ifa.toggle_i[2];
      step_n(4);
    end
    n_checks++; if (ifa.count_o !== 8'h30) begin n_fail++; $display("FAIL pp_fill: got %h exp 30", ifa.count_o); end
    ifa.toggle_i[2] = ~ifa.toggle_i[2];
    step_n(2);
    n_checks++; if (ifa.pulse_o !== 4'b0100) begin n_fail++; $display("FAIL pp_pulse: got %b exp 0100", ifa.pulse_o); end
    ifa.ready_i[2] = 1'b1;
    step();
    ifa.ready_i = '0;
    n_checks++; if (ifa.count_o !== 8'h30) begin n_fail++; $display("FAIL pp_count: got %h exp 30", ifa.count_o); end
    n_checks++; if (ifa.ovf_o !== 4'b0000) begin n_fail++; $display("FAIL pp_no_ovf: got %b exp 0000", ifa.ovf_o); end
    step();
    ifa.toggle_i[2] = ~ifa.toggle_i[2];
    step_n(2);
    ifa.ovf_clr_i[2] = 1'b1;
    step();
    ifa.ovf_clr_i = '0;
    n_checks++; if (ifa.ovf_o !== 4'b0100) begin n_fail++; $display("FAIL pp_set_wins: got %b exp 0100", ifa.ovf_o); end
    step();
    n_checks++; if (ifa.ovf_o !== 4'b0100) begin n_fail++; $display("FAIL pp_ovf_sticky: got %b exp 0100", ifa.ovf_o); end
    // Build counts {ch3..ch0} = {1,3,0,2} with ovf on ch0 and ch2.
    ifa.toggle_i = ifa.toggle_i ^ 4'b1001;
    step_n(4);
    n_checks++; if (ifa.count_o !== 8'h71) begin n_fail++; $display("FAIL pp_multi: got %h exp 71", ifa.count_o); end
    for (int k = 0; k < 3; k++) begin
      ifa.toggle_i[0] = ~ifa.toggle_i[0];
      step_n(4);
    end
    ifa.ready_i[0] = 1'b1;
    step();
    ifa.ready_i = '0;
    n_checks++; if (ifa.count_o !== 8'h72) begin n_fail++; $display("FAIL pp_state_count: got %h exp 72", ifa.count_o); end
    n_checks++; if (ifa.ovf_o !== 4'b0101) begin n_fail++; $display("FAIL pp_state_ovf: got %b exp 0101", ifa.ovf_o); end
    n_checks++; if (ifa.valid_o !== 4'b1101) begin n_fail++; $display("FAIL pp_state_valid: got %b exp 1101", ifa.valid_o); end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] seen;
    rst = 1'b1;
    #1;
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL mid_rst_count: got %h exp 00", ifa.count_o); end
    n_checks++; if (ifa.ovf_o !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ovf: got %b exp 0000", ifa.ovf_o); end
    n_checks++; if (ifa.valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0000", ifa.valid_o); end
    step();
    rst = 1'b0;
    seen = '0;
    repeat (6) begin step(); seen |= ifa.pulse_o | ifb.pulse_o; end
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_spurious: got %b exp 0000", seen); end
    n_checks++; if (ifa.count_o !== 8'h00) begin n_fail++; $display("FAIL mid_rst_count_after: got %h exp 00", ifa.count_o); end
  endtask

  task automatic test_pulse_only();
    ifb.ready_i   = 4'b1111;
    ifb.ovf_clr_i = 4'b1111;
    ifb.toggle_i  = 4'b1111;
    step();  // E0
    n_checks++; if (ifb.pulse_o !== 4'b0000) begin n_fail++; $display("FAIL po_pulse_e0: got %b exp 0000", ifb.pulse_o); end
    step();  // E1
    n_checks++; if (ifb.pulse_o !== 4'b0000) begin n_fail++; $display("FAIL po_pulse_e1: got %b exp 0000", ifb.pulse_o); end
    step();  // E2
    n_checks++; if (ifb.pulse_o !== 4'b1111) begin n_fail++; $display("FAIL po_pulse_e2: got %b exp 1111", ifb.pulse_o); end
    n_checks++; if (ifb.valid_o !== 4'b0000) begin n_fail++; $display("FAIL po_valid: got %b exp 0000", ifb.valid_o); end
    step();  // E3
    n_checks++; if (ifb.pulse_o !== 4'b0000) begin n_fail++; $display("FAIL po_pulse_e3: got %b exp 0000", ifb.pulse_o); end
    n_checks++; if (ifb.count_o !== 16'h0000) begin n_fail++; $display("FAIL po_count: got %h exp 0000", ifb.count_o); end
    n_checks++; if (ifb.ovf_o !== 4'b0000) begin n_fail++; $display("FAIL po_ovf: got %b exp 0000", ifb.ovf_o); end
    ifb.ready_i   = '0;
    ifb.ovf_clr_i = '0;
  endtask

  initial begin
    rst = 1'b0;
    #2;
    test_reset();
    test_basic_latency();
    test_init_suppression();
    test_saturation();
    test_simul_push_pop();
    test_reset_mid_op();
    test_pulse_only();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/prim_event_sync_rx.md
# prim_event_sync_rx

Multi-channel receive side for toggle-encoded events crossing into the `clk_i` domain. Each of `NumCh` channels takes an asynchronous toggle level from a foreign-domain toggle flop. It synchronises the level through a configurable flop chain and converts every observed level change into one event. In counted mode, each channel also buffers events in a saturating pending counter that is drained through a valid/ready handshake and has a sticky overflow flag. The block is the parametrised successor of the single-channel pulse synchroniser and sits at the destination end of interrupt, alert and status-event crossings.

## Interface
Parameters:
- `NumCh`, default 4: number of independent channels, ≥1.
- `SyncStages`, default 2: synchroniser depth, ≥2.
- `CntW`, default 4: pending-counter width, ≥1; saturation value is 2^CntW−1.
- `Counted`, default 1: 0 selects pulse-only mode; 1 selects pulse plus counter/handshake.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: asynchronous, active-high reset; deassertion is synchronous to `clk_i` externally.
- `toggle_i`, in, NumCh: asynchronous toggle levels, one per channel.
- `pulse_o`, out, NumCh: one-cycle event pulse per detected toggle.
- `valid_o`, out, NumCh: the channel has at least one pending event.
- `ready_i`, in, NumCh: consumer pops one pending event when `valid_o` and `ready_i` are both high.
- `count_o`, out, NumCh*CntW: pending count; channel c occupies bits [c*CntW +: CntW].
- `ovf_o`, out, NumCh: sticky overflow, meaning an event was lost.
- `ovf_clr_i`, in, NumCh: clears `ovf_o` for the channel.

## Operation
- **Reset values.** While `rst_i` is high, all synchroniser flops, `prev` flops, counters and overflow flags are 0, and the init window is armed.
- **Outputs during reset.** `pulse_o`=0, `valid_o`=0, `count_o`=0, `ovf_o`=0.
- **Synchroniser.** Per channel, a chain of `SyncStages` flops. `sync` is the last stage.
- **Edge detection.** A `prev` flop per channel registers `sync` every cycle. The raw event is `sync ^ prev`.
- **Init window.** This is the first `SyncStages`+1 cycles after reset deassertion.
  - It is implemented with a shared down-counter; no per-channel state.
  - During the window, events are suppressed while `prev` keeps tracking `sync`.
  - This ensures a `toggle_i` already high at reset release produces no event.
- **`pulse_o[c]`.** Equals the raw event ANDed with NOT init. It is driven only from flops, so it is glitch-free. It is active in both modes.
- **Counted=1, per channel:**
  - push = event; pop = `valid_o` & `ready_i`.
  - push & !pop: count+1 if count < max; otherwise the count is held and `ovf` is set (the event is lost).
  - !push & pop: count−1.
  - push & pop: count unchanged, even at max; no overflow.
  - `valid_o` = (count ≠ 0). `ready_i` while `valid_o`=0 has no effect.
  - `ovf`: a set and `ovf_clr_i` in the same cycle leaves `ovf`=1 (set wins). Otherwise `ovf_clr_i` clears it.
- **Counted=0.** No counter or overflow flops exist. `valid_o`, `count_o` and `ovf_o` are tied to 0. `ready_i` and `ovf_clr_i` are ignored.
- **Channel independence.** Channels are fully independent. Simultaneous events on multiple channels are all captured.
- **Event spacing.** Source toggles on one channel are guaranteed by the sender to be spaced at least `SyncStages`+1 `clk_i` cycles apart. Closer toggles may merge, which is not an error.

## Timing
- **First capturing edge.** Let E0 be the first rising `clk_i` edge that samples the new `toggle_i` level.
- **Pulse timing.** `sync` changes at edge E0+`SyncStages`−1. `pulse_o` is high for exactly the one cycle between E0+`SyncStages`−1 and E0+`SyncStages`. With `SyncStages`=2, `pulse_o` is high from E1 to E2.
- **Counter timing.** The counter updates at the edge that ends the pulse cycle. `valid_o` rises in the following cycle, E0+`SyncStages`.
- **Pop timing.** A pop takes effect at the clock edge where `valid_o` & `ready_i` are sampled. `valid_o` may fall in the next cycle. Sustained `ready_i` drains one event per cycle.
- **Overflow timing.** `ovf_o` rises one cycle after the lost push.
- **Combinational paths.** There is no path from `ready_i` to `valid_o`, and none from inputs to outputs.
- **Asynchronous reset mid-operation.** Asserting `rst_i` clears all state immediately. Pending events are discarded, and the init window re-arms on release.

## Test plan
- **Basic latency:** SyncStages=2, Counted=1. Reset, then toggle ch0 0→1 and hold `ready_i`=0 → one `pulse_o[0]` cycle at E1–E2; `count_o[0]`=1 and `valid_o[0]`=1 from E2; other channels stay 0.
- **Init suppression:** hold `toggle_i`=4'b1010 through reset release → no `pulse_o` and all counts 0 after the init window. A later ch1 toggle produces exactly one pulse.
- **Saturation:** CntW=2, `ready_i`=0. Apply 4 ch2 toggles spaced 4 cycles → count reaches 3 after toggle 3; toggle 4 sets `ovf_o[2]` and count stays 3. Then `ovf_clr_i[2]` → `ovf_o[2]`=0. Drive `ready_i[2]`=1 for 3 cycles → count 3,2,1,0 and `valid_o[2]` low.
- **Simultaneous push/pop:** count=3 (max) with push and pop in the same cycle → count stays 3 and no overflow. A coincident set and clear of `ovf` → `ovf_o`=1.
- **Reset mid-operation:** pulse `rst_i` for 1 cycle with counts {2,0,3,1} and `ovf_o[0]`=1 → all outputs 0 and no spurious pulses afterwards.
- **Pulse-only mode:** Counted=0, SyncStages=3. Toggle all channels together → all `pulse_o` high for one cycle at E2–E3; `valid_o`, `count_o` and `ovf_o` remain 0.
